// File: rtl/sram_banked_unaligned_pkg.sv
// Shared constants and helpers for the banked, unaligned-read local buffer SRAM.
package sram_banked_unaligned_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Default geometry and its derived widths; modules re-derive from their own parameters.
  localparam int unsigned DEF_WORD_BYTES = 8;
  localparam int unsigned DEF_N_BANKS    = 2;
  localparam int unsigned DEF_DEPTH      = 1024;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned OFF_W          = clog2(DEF_WORD_BYTES);
  localparam int unsigned BANK_W         = clog2(DEF_N_BANKS);
  localparam int unsigned ROW_W          = clog2(DEF_DEPTH / DEF_N_BANKS);

  // Upper bound for the byte-window helper; callers zero-extend and truncate.
  localparam int unsigned MAX_WORD_BYTES = 64;
  localparam int unsigned MAX_DW         = 8 * MAX_WORD_BYTES;
  localparam int unsigned MAX_OFF_W      = 6;

  // Little-endian window: bytes off .. off+WORD_BYTES-1 of {hi, lo}.
  function automatic logic [MAX_DW-1:0] byte_window(
    input logic [2*MAX_DW-1:0] pair,
    input logic [MAX_OFF_W-1:0] off
  );
    return MAX_DW'(pair >> {off, 3'b000});
  endfunction

endpackage

// File: rtl/sram_banked_unaligned_bank.sv
// Single-port byte-enable block RAM with a registered read port; contents are not reset.
module sram_bank
  import sram_banked_unaligned_pkg::*;
#(
  parameter int unsigned ROWS       = 512,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned WORD_BYTES = 8
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [ROW_W-1:0]        addr_i,
  input  logic [WORD_BYTES-1:0]   be_i,
  input  logic [8*WORD_BYTES-1:0] wdata_i,
  output logic [8*WORD_BYTES-1:0] rdata_o
);

  logic [8*WORD_BYTES-1:0] mem_q [ROWS];
  logic [8*WORD_BYTES-1:0] rdata_q;

  // The read register only updates on a read, so it holds across stalls and writes.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_banked_unaligned.sv
// Word-interleaved multi-bank SRAM with unaligned byte-window reads and a 2-stage read pipeline.
module sram_banked_unaligned
  import sram_banked_unaligned_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned N_BANKS    = 2,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [WORD_BYTES-1:0]   req_be_i,
  input  logic [8*WORD_BYTES-1:0] req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [8*WORD_BYTES-1:0] rsp_rdata_o,
  output logic                    rsp_err_o
);

  localparam int unsigned DW      = 8 * WORD_BYTES;
  localparam int unsigned L_OFF_W = clog2(WORD_BYTES);
  localparam int unsigned L_BNK_W = clog2(N_BANKS);
  localparam int unsigned ROWS    = DEPTH / N_BANKS;
  localparam int unsigned L_ROW_W = (ROWS > 1) ? clog2(ROWS) : 1;
  localparam int unsigned WORD_W  = ADDR_WIDTH - L_OFF_W;

  localparam logic [WORD_W-1:0] DEPTH_L = WORD_W'(DEPTH);
  localparam logic [WORD_W-1:0] LAST_L  = WORD_W'(DEPTH - 1);

  logic [L_OFF_W-1:0] off;
  logic [WORD_W-1:0]  word;
  logic [WORD_W-1:0]  word_nx;
  logic [L_BNK_W-1:0] bank;
  logic [L_BNK_W-1:0] bank_nx;
  logic [L_ROW_W-1:0] row;
  logic [L_ROW_W-1:0] row_nx;
  logic               in_range;

  logic stall;
  logic acc;
  logic acc_rd;
  logic acc_wr;

  logic               s1_valid_q, s1_valid_d;
  logic [L_OFF_W-1:0] s1_off_q, s1_off_d;
  logic [L_BNK_W-1:0] s1_bank_q, s1_bank_d;
  logic               s1_err_q, s1_err_d;
  logic [L_BNK_W-1:0] s1_bank_hi;

  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [N_BANKS-1:0] bank_en;
  logic [L_ROW_W-1:0] bank_addr [N_BANKS];
  logic [DW-1:0]      bank_rdata [N_BANKS];
  logic [DW-1:0]      win_lo;
  logic [DW-1:0]      win_hi;
  logic [2*MAX_DW-1:0] win_pair;
  logic [DW-1:0]      window;

  // Address decode; the successor word wraps at the top of the array.
  assign off      = req_addr_i[L_OFF_W-1:0];
  assign word     = req_addr_i[ADDR_WIDTH-1:L_OFF_W];
  assign in_range = (word < DEPTH_L);
  assign word_nx  = (word == LAST_L) ? '0 : word + 1'b1;
  assign bank     = word[L_BNK_W-1:0];
  assign bank_nx  = word_nx[L_BNK_W-1:0];
  assign row      = L_ROW_W'(word >> L_BNK_W);
  assign row_nx   = L_ROW_W'(word_nx >> L_BNK_W);

  assign stall       = rsp_valid_q & ~rsp_ready_i;
  assign req_ready_o = rst_n_i & ~(stall & s1_valid_q);
  assign acc         = req_valid_i & req_ready_o;
  assign acc_rd      = acc & ~req_we_i;
  assign acc_wr      = acc & req_we_i & (off == '0) & in_range;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    // A bank serves the word itself or its successor, whichever maps to it.
    assign bank_addr[b] = (bank == L_BNK_W'(b)) ? row : row_nx;
    assign bank_en[b]   = (acc_rd & in_range & ((bank == L_BNK_W'(b)) | (bank_nx == L_BNK_W'(b))))
                        | (acc_wr & (bank == L_BNK_W'(b)));

    sram_bank #(
      .ROWS       (ROWS),
      .ROW_W      (L_ROW_W),
      .WORD_BYTES (WORD_BYTES)
    ) u_bank (
      .clk_i   (clk_i),
      .en_i    (bank_en[b]),
      .we_i    (acc_wr),
      .addr_i  (bank_addr[b]),
      .be_i    (req_be_i),
      .wdata_i (req_wdata_i),
      .rdata_o (bank_rdata[b])
    );
  end

  assign s1_bank_hi = s1_bank_q + 1'b1;
  assign win_lo     = bank_rdata[s1_bank_q];
  assign win_hi     = bank_rdata[s1_bank_hi];
  assign win_pair   = (2*MAX_DW)'({win_hi, win_lo});
  assign window     = DW'(byte_window(win_pair, MAX_OFF_W'(s1_off_q)));

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_off_d    = s1_off_q;
    s1_bank_d   = s1_bank_q;
    s1_err_d    = s1_err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    if (acc_rd) begin
      s1_valid_d = 1'b1;
      s1_off_d   = off;
      s1_bank_d  = bank;
      s1_err_d   = ~in_range;
    end else if (!stall) begin
      s1_valid_d = 1'b0;
    end

    if (!stall) begin
      rsp_valid_d = s1_valid_q;
      rsp_err_d   = s1_valid_q & s1_err_q;
      if (s1_valid_q) begin
        rsp_rdata_d = s1_err_q ? '0 : window;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_valid_q  <= 1'b0;
      s1_off_q    <= '0;
      s1_bank_q   <= '0;
      s1_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_off_q    <= s1_off_d;
      s1_bank_q   <= s1_bank_d;
      s1_err_q    <= s1_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_sram_banked_unaligned.sv
// Self-checking bench: flat byte-array reference model with an in-order expected-response queue.
module tb_sram_banked_unaligned;

  localparam int unsigned WB     = 8;
  localparam int unsigned NB     = 2;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 8 * WB;
  localparam int unsigned NBYTES = DEPTH * WB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [WB-1:0] req_be;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  sram_banked_unaligned #(
    .WORD_BYTES (WB),
    .N_BANKS    (NB),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_be_i    (req_be),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [7:0]    mem [NBYTES];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          acc;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_err;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model_read(input int unsigned a);
    exp_t e;
    e.data = '0;
    e.err  = 1'b0;
    if (a / WB >= DEPTH) begin
      e.err = 1'b1;
    end else begin
      for (int i = 0; i < WB; i++) begin
        e.data[8*i +: 8] = mem[(a + i) % NBYTES];
      end
    end
    return e;
  endfunction

  task automatic model_write(input int unsigned a, input logic [WB-1:0] be, input logic [DW-1:0] d);
    if ((a % WB == 0) && (a / WB < DEPTH)) begin
      for (int i = 0; i < WB; i++) begin
        if (be[i]) mem[a + i] = d[8*i +: 8];
      end
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      acc = req_valid && req_ready;
      if (prev_stall) begin
        chk("stall_hold_valid", rsp_valid, 1);
        chk("stall_hold_data", rsp_rdata, prev_data);
        chk("stall_hold_err", rsp_err, prev_err);
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_rdata;
      prev_err   = rsp_err;
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.data);
          chk("rsp_err", rsp_err, e.err);
        end
      end
      if (acc) begin
        if (req_we) model_write(req_addr, req_be, req_wdata);
        else exp_q.push_back(model_read(req_addr));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input int unsigned a, input logic [WB-1:0] be,
                        input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_be    = be;
    req_wdata = d;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    chk("req_accept", acc, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int unsigned   bp [4];
    int unsigned   idx;
    int unsigned   a;
    int unsigned   r;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", req_ready, 1);

    for (int unsigned w = 0; w < DEPTH; w++) begin
      d = {$urandom, $urandom};
      if (w == 0)         d = 64'h0706050403020100;
      if (w == 1)         d = 64'h0F0E0D0C0B0A0908;
      if (w == DEPTH - 1) d = 64'hFFFEFDFCFBFAF9F8;
      do_req(1'b1, w * WB, '1, d);
    end

    // Aligned write then read, with explicit 2-cycle latency check.
    do_req(1'b1, 32'h10, 8'hFF, 64'h0706050403020100);
    do_req(1'b0, 32'h10, '0, '0);
    chk("lat1_not_valid", rsp_valid, 0);
    tick();
    chk("lat2_valid", rsp_valid, 1);
    drain();

    do_req(1'b0, 32'h03, '0, '0);
    do_req(1'b0, (DEPTH - 1) * WB + 6, '0, '0);
    drain();

    do_req(1'b1, 5 * WB, 8'hFF, {8{8'h11}});
    do_req(1'b1, 5 * WB, 8'h0F, {8{8'hAA}});
    do_req(1'b0, 5 * WB, '0, '0);
    do_req(1'b0, 32'h2000, '0, '0);
    do_req(1'b1, 5 * WB + 1, 8'hFF, {$urandom, $urandom});
    do_req(1'b0, 5 * WB, '0, '0);
    do_req(1'b0, 5 * WB - 3, '0, '0);
    drain();

    // Backpressure: consumer stalls for five cycles while four reads are offered.
    for (int i = 0; i < 4; i++) bp[i] = $urandom_range(0, NBYTES - 1);
    idx = 0;
    for (int c = 0; c < 40 && (idx < 4 || exp_q.size() != 0); c++) begin
      rsp_ready = (c >= 5);
      req_valid = (idx < 4);
      req_we    = 1'b0;
      if (idx < 4) req_addr = bp[idx];
      tick();
      if (acc) idx++;
      if (c == 4) begin
        chk("bp_accepts", idx, 2);
        chk("bp_ready_low", req_ready, 0);
      end
    end
    chk("bp_all_done", (idx == 4) && (exp_q.size() == 0), 1);
    drain();

    for (int c = 0; c < 600; c++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = ($urandom_range(0, 9) < 3);
      a = $urandom_range(0, NBYTES - 1);
      r = $urandom_range(0, 19);
      if (req_we && r != 0) a = a & ~(WB - 1);
      if (r == 1) a = NBYTES + $urandom_range(0, 4095);
      req_addr  = a;
      req_be    = WB'($urandom);
      req_wdata = {$urandom, $urandom};
      tick();
    end
    drain();

    // Reset with two reads in flight: no response may survive it, RAM keeps its data.
    do_req(1'b0, 32'h10, '0, '0);
    do_req(1'b0, 32'h18, '0, '0);
    rst_n = 1'b0;
    tick();
    chk("midrst_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("midrst_no_stale", rsp_valid, 0);
    do_req(1'b0, 32'h10, '0, '0);
    do_req(1'b0, 32'h03, '0, '0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
